// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: controller state encoding,
// default queue depth and the serializer byte width.
package uart_pkg;

   localparam int UART_DEPTH  = 16;
   localparam int UART_BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_DONE = 2'd2
   } txState_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte queue feeding the UART controller: pointers, occupancy count,
// registered full/empty flags and a sticky overflow flag for dropped writes.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = UART_DEPTH,
   parameter int DATA_W = UART_BYTE_W
) (
   input  logic                     i_Clock,
   input  logic                     i_Rst_L,
   input  logic                     i_Wr_En,
   input  logic [DATA_W-1:0]        i_Wr_Data,
   input  logic                     i_Pop,
   input  logic                     i_Ovf_Clr,
   output logic [DATA_W-1:0]        o_Rd_Data,
   output logic                     o_Wr_Accept,
   output logic                     o_Full,
   output logic                     o_Empty,
   output logic [$clog2(DEPTH):0]   o_Count,
   output logic                     o_Overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, empty_q;
   logic              overflow_q, overflow_d;
   logic              wrAccept, wrDrop, doPop;

   // A write is judged against the full flag as it stands, so a write on a
   // full queue is dropped even if the head is popped in the same cycle.
   assign wrAccept = i_Wr_En && !full_q;
   assign wrDrop   = i_Wr_En && full_q;
   assign doPop    = i_Pop && !empty_q;

   always_comb begin
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (wrAccept) begin
         wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
         rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      case ({wrAccept, doPop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (wrDrop) begin
         overflow_d = 1'b1;
      end else if (i_Ovf_Clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         full_q     <= (count_d == CNT_W'(DEPTH));
         empty_q    <= (count_d == '0);
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (wrAccept) begin
         mem_q[wrPtr_q] <= i_Wr_Data;
      end
   end

   assign o_Rd_Data   = mem_q[rdPtr_q];
   assign o_Wr_Accept = wrAccept;
   assign o_Full      = full_q;
   assign o_Empty     = empty_q;
   assign o_Count     = count_q;
   assign o_Overflow  = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// CPU-side byte queue in front of a UART serializer: launches one byte per
// frame and raises an interrupt when the last queued byte has gone out.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH  = UART_DEPTH,
   parameter int DATA_W = UART_BYTE_W
) (
   input  logic                     i_Clock,
   input  logic                     i_Rst_L,
   input  logic                     i_Wr_En,
   input  logic [DATA_W-1:0]        i_Wr_Data,
   input  logic                     i_Irq_En,
   input  logic                     i_Irq_Clr,
   input  logic                     i_TX_Active,
   input  logic                     i_TX_Done,
   output logic                     o_Full,
   output logic                     o_Empty,
   output logic [$clog2(DEPTH):0]   o_Count,
   output logic                     o_Overflow,
   output logic                     o_Irq,
   output logic                     o_TX_DV,
   output logic [DATA_W-1:0]        o_TX_Byte
);

   txState_e          state_q, state_d;
   logic              txDv_q, txDv_d;
   logic [DATA_W-1:0] txByte_q, txByte_d;
   logic              irq_q, irq_d;
   logic              irqSet;
   logic              pop;
   logic              fifoEmpty;
   logic              wrAccept;
   logic [DATA_W-1:0] headByte;

   uart_byte_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .i_Clock     (i_Clock),
      .i_Rst_L     (i_Rst_L),
      .i_Wr_En     (i_Wr_En),
      .i_Wr_Data   (i_Wr_Data),
      .i_Pop       (pop),
      .i_Ovf_Clr   (i_Irq_Clr),
      .o_Rd_Data   (headByte),
      .o_Wr_Accept (wrAccept),
      .o_Full      (o_Full),
      .o_Empty     (fifoEmpty),
      .o_Count     (o_Count),
      .o_Overflow  (o_Overflow)
   );

   // IDLE deliberately ignores i_TX_Done: the serializer may still hold Done
   // high in the cycle after it returns us to IDLE.
   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      txByte_d = txByte_q;
      case (state_q)
         ST_IDLE: begin
            if (!fifoEmpty && !i_TX_Active) begin
               state_d  = ST_LAUNCH;
               pop      = 1'b1;
               txByte_d = headByte;
            end
         end
         ST_LAUNCH: begin
            state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (i_TX_Done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      txDv_d = (state_d == ST_LAUNCH);

      irqSet = i_Irq_En && (state_q == ST_WAIT_DONE) && i_TX_Done && fifoEmpty;
      irq_d  = irq_q;
      if (irqSet) begin
         irq_d = 1'b1;
      end else if (i_Irq_Clr || wrAccept) begin
         irq_d = 1'b0;
      end
   end

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q  <= ST_IDLE;
         txDv_q   <= 1'b0;
         txByte_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         txDv_q   <= txDv_d;
         txByte_q <= txByte_d;
         irq_q    <= irq_d;
      end
   end

   assign o_Empty   = fifoEmpty;
   assign o_TX_DV   = txDv_q;
   assign o_TX_Byte = txByte_q;
   assign o_Irq     = irq_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed scenarios plus random traffic, checked by
// a scoreboard of accepted bytes and a simple occupancy/overflow model.
module tb_uart_tx_feeder;

   localparam int DEPTH = 16;

   logic       i_Clock = 1'b0;
   logic       i_Rst_L;
   logic       i_Wr_En;
   logic [7:0] i_Wr_Data;
   logic       i_Irq_En;
   logic       i_Irq_Clr;
   logic       i_TX_Active;
   logic       i_TX_Done;
   logic       o_Full;
   logic       o_Empty;
   logic [4:0] o_Count;
   logic       o_Overflow;
   logic       o_Irq;
   logic       o_TX_DV;
   logic [7:0] o_TX_Byte;

   logic [7:0] expQ [$];
   int         accepted = 0;
   int         launched = 0;
   bit         ovfModel = 1'b0;
   int         vectors = 0;
   int         miscompares = 0;

   int         frameLen = 4;
   int         doneLen = 1;
   bit         serBlock = 1'b0;
   bit         serActive = 1'b0;
   int         busyLeft = 0;
   int         doneLeft = 0;

   assign i_TX_Active = serActive | serBlock;

   uart_tx_feeder #(
      .DEPTH  (DEPTH),
      .DATA_W (8)
   ) dut (
      .i_Clock     (i_Clock),
      .i_Rst_L     (i_Rst_L),
      .i_Wr_En     (i_Wr_En),
      .i_Wr_Data   (i_Wr_Data),
      .i_Irq_En    (i_Irq_En),
      .i_Irq_Clr   (i_Irq_Clr),
      .i_TX_Active (i_TX_Active),
      .i_TX_Done   (i_TX_Done),
      .o_Full      (o_Full),
      .o_Empty     (o_Empty),
      .o_Count     (o_Count),
      .o_Overflow  (o_Overflow),
      .o_Irq       (o_Irq),
      .o_TX_DV     (o_TX_DV),
      .o_TX_Byte   (o_TX_Byte)
   );

   always #5 i_Clock = ~i_Clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic nextSlot();
      @(negedge i_Clock);
      #1;
   endtask

   // Drives one cycle of CPU-side inputs and updates the reference model with
   // what the queue must do with them at the coming edge.
   task automatic applyStimulus(input bit wr, input logic [7:0] d, input bit clr);
      bit dropped;
      dropped = 1'b0;
      if (wr) begin
         if (accepted - launched < DEPTH) begin
            accepted++;
            expQ.push_back(d);
         end else begin
            dropped = 1'b1;
         end
      end
      if (dropped) ovfModel = 1'b1;
      else if (clr) ovfModel = 1'b0;
      i_Wr_En   = wr;
      i_Wr_Data = d;
      i_Irq_Clr = clr;
      nextSlot();
      i_Wr_En   = 1'b0;
      i_Irq_Clr = 1'b0;
   endtask

   task automatic resetDut();
      i_Rst_L  = 1'b0;
      serBlock = 1'b0;
      expQ.delete();
      accepted = 0;
      launched = 0;
      ovfModel = 1'b0;
      #1;
      checkOutput("rst_tx_dv", o_TX_DV, 0);
      checkOutput("rst_tx_byte", o_TX_Byte, 0);
      checkOutput("rst_count", o_Count, 0);
      checkOutput("rst_empty", o_Empty, 1);
      checkOutput("rst_full", o_Full, 0);
      checkOutput("rst_irq", o_Irq, 0);
      checkOutput("rst_overflow", o_Overflow, 0);
      repeat (2) nextSlot();
      i_Rst_L = 1'b1;
      nextSlot();
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while ((expQ.size() != 0 || serActive || i_TX_Done) && n < budget) begin
         nextSlot();
         n++;
      end
      checkOutput("drain_timeout", expQ.size(), 0);
      repeat (3) nextSlot();
   endtask

   // Serializer stand-in: busy for frameLen cycles after each launch, then
   // pulses Done for doneLen cycles.
   initial begin : serializer
      i_TX_Done = 1'b0;
      forever begin
         @(negedge i_Clock);
         if (!i_Rst_L) begin
            serActive = 1'b0;
            i_TX_Done = 1'b0;
            busyLeft  = 0;
            doneLeft  = 0;
         end else if (o_TX_DV) begin
            serActive = 1'b1;
            i_TX_Done = 1'b0;
            busyLeft  = frameLen;
            doneLeft  = 0;
         end else if (busyLeft > 0) begin
            busyLeft--;
            if (busyLeft == 0) begin
               serActive = 1'b0;
               i_TX_Done = 1'b1;
               doneLeft  = doneLen - 1;
            end
         end else if (doneLeft > 0) begin
            doneLeft--;
         end else begin
            i_TX_Done = 1'b0;
         end
      end
   end

   // Scoreboard monitor: every launch must carry the oldest accepted byte, and
   // occupancy flags must track accepted minus launched bytes.
   initial begin : monitor
      bit prevDv;
      prevDv = 1'b0;
      forever begin
         @(negedge i_Clock);
         if (i_Rst_L) begin
            if (o_TX_DV) begin
               checkOutput("dv_single_cycle", prevDv, 0);
               if (expQ.size() == 0) checkOutput("unexpected_launch", o_TX_DV, 0);
               else checkOutput("tx_byte_order", o_TX_Byte, expQ.pop_front());
               launched++;
            end
            checkOutput("count", o_Count, accepted - launched);
            checkOutput("empty", o_Empty, (accepted == launched));
            checkOutput("full", o_Full, (accepted - launched == DEPTH));
            checkOutput("overflow", o_Overflow, ovfModel);
         end
         prevDv = o_TX_DV;
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: time limit reached with %0d bytes still expected", expQ.size());
      $fatal(1, "[TB] simulation aborted by watchdog");
   end

   initial begin : stimulus
      int irqRises;
      bit prevIrq;
      int launchBase;
      int r;
      i_Rst_L   = 1'b0;
      i_Wr_En   = 1'b0;
      i_Wr_Data = 8'h00;
      i_Irq_En  = 1'b0;
      i_Irq_Clr = 1'b0;
      nextSlot();
      resetDut();

      // Single byte latency
      applyStimulus(1'b1, 8'h55, 1'b0);
      checkOutput("latency_n1_dv", o_TX_DV, 0);
      nextSlot();
      checkOutput("latency_n2_dv", o_TX_DV, 1);
      checkOutput("latency_n2_byte", o_TX_Byte, 8'h55);
      checkOutput("latency_count", o_Count, 0);
      nextSlot();
      checkOutput("latency_n3_dv", o_TX_DV, 0);
      waitDrain(100);

      // Burst to full, then one dropped write
      serBlock = 1'b1;
      for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 8'(i), 1'b0);
      checkOutput("burst_full", o_Full, 1);
      checkOutput("burst_count", o_Count, 16);
      applyStimulus(1'b1, 8'hFF, 1'b0);
      checkOutput("burst_overflow", o_Overflow, 1);
      checkOutput("burst_count_after_drop", o_Count, 16);
      serBlock = 1'b0;
      waitDrain(400);
      checkOutput("overflow_sticky", o_Overflow, 1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("overflow_cleared", o_Overflow, 0);

      // Interrupt after last byte, Done held for two cycles
      i_Irq_En   = 1'b1;
      doneLen    = 2;
      launchBase = launched;
      applyStimulus(1'b1, 8'hC3, 1'b0);
      irqRises = 0;
      prevIrq  = o_Irq;
      for (int k = 0; k < 20; k++) begin
         nextSlot();
         if (o_Irq && !prevIrq) irqRises++;
         prevIrq = o_Irq;
      end
      checkOutput("irq_rises", irqRises, 1);
      checkOutput("irq_single_launch", launched - launchBase, 1);
      checkOutput("irq_sticky", o_Irq, 1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("irq_cleared", o_Irq, 0);
      doneLen = 1;

      // Masked set, mask does not clear, accepted write clears
      i_Irq_En = 1'b0;
      applyStimulus(1'b1, 8'h11, 1'b0);
      waitDrain(100);
      checkOutput("irq_masked", o_Irq, 0);
      i_Irq_En = 1'b1;
      applyStimulus(1'b1, 8'h22, 1'b0);
      waitDrain(100);
      checkOutput("irq_set_again", o_Irq, 1);
      i_Irq_En = 1'b0;
      nextSlot();
      checkOutput("irq_mask_keeps", o_Irq, 1);
      serBlock = 1'b1;
      applyStimulus(1'b1, 8'h3C, 1'b0);
      checkOutput("irq_cleared_by_write", o_Irq, 0);
      serBlock = 1'b0;
      waitDrain(100);

      // Write on the pop edge keeps the count, then push pointers past a wrap
      serBlock = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h40 + 8'(i), 1'b0);
      serBlock = 1'b0;
      applyStimulus(1'b1, 8'h44, 1'b0);
      checkOutput("simul_wr_pop_count", o_Count, 4);
      for (int i = 0; i < 35; i++) begin
         applyStimulus(1'b1, 8'($urandom), 1'b0);
         repeat ($urandom_range(0, 4)) nextSlot();
      end
      waitDrain(2000);

      // Reset while waiting on a frame with three bytes queued
      frameLen = 30;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0);
      repeat (6) nextSlot();
      checkOutput("pre_reset_count", o_Count, 3);
      resetDut();
      frameLen = 4;
      repeat (12) nextSlot();
      checkOutput("post_reset_idle_empty", o_Empty, 1);
      applyStimulus(1'b1, 8'h5A, 1'b0);
      nextSlot();
      checkOutput("prelaunch_dv", o_TX_DV, 1);
      resetDut();
      applyStimulus(1'b1, 8'h6B, 1'b0);
      waitDrain(100);

      // Random traffic
      for (int it = 0; it < 1500; it++) begin
         frameLen = $urandom_range(1, 6);
         doneLen  = $urandom_range(1, 2);
         if ($urandom_range(0, 19) == 0) serBlock = ~serBlock;
         r = $urandom_range(0, 99);
         applyStimulus(r < 55, 8'($urandom), r >= 95);
      end
      serBlock = 1'b0;
      waitDrain(2000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter: DEPTH, 16, FIFO depth in bytes; power of two, 2..256.
REQ-002 Parameter: DATA_W, 8, byte width; fixed at 8 for the serializer.
REQ-003 i_Clock  input  1  single clock; all state changes on its rising edge.
REQ-004 i_Rst_L  input  1  asynchronous active-low reset.
REQ-005 i_Wr_En  input  1  CPU byte-write strobe, one byte per high cycle.
REQ-006 i_Wr_Data  input  8  byte to enqueue.
REQ-007 i_Irq_En  input  1  enables the empty-after-send interrupt.
REQ-008 i_Irq_Clr  input  1  one-cycle clear for o_Irq and o_Overflow.
REQ-009 o_Full / o_Empty  output  1 each  FIFO full, FIFO empty (registered).
REQ-010 o_Count  output  clog2(DEPTH)+1  bytes currently queued.
REQ-011 o_Overflow  output  1  sticky: a write was dropped while full.
REQ-012 o_Irq  output  1  sticky level interrupt to the interrupt controller.
REQ-013 o_TX_DV  output  1  one-cycle launch strobe to the serializer.
REQ-014 o_TX_Byte  output  8  byte for the serializer; stable while o_TX_DV is high.
REQ-015 i_TX_Active / i_TX_Done  input  1 each  serializer busy, serializer frame-complete.

Function
REQ-016 FIFO: circular buffer, read/write pointers of clog2(DEPTH) bits, wrap modulo DEPTH.
REQ-017 Write while not full: enqueue; o_Count increments the following cycle.
REQ-018 Write while full: drop the byte, leave the FIFO unchanged, set o_Overflow.
REQ-019 Write and pop in the same cycle: both take effect; o_Count unchanged.
REQ-020 Controller FSM states: IDLE, LAUNCH, WAIT_DONE.
REQ-021 IDLE -> LAUNCH when FIFO not empty and i_TX_Active low; pop the head into o_TX_Byte on that edge.
REQ-022 LAUNCH: o_TX_DV=1 for exactly one cycle; next state is WAIT_DONE.
REQ-023 WAIT_DONE -> IDLE on the first cycle i_TX_Done=1; otherwise hold.
REQ-024 IDLE ignores i_TX_Done, because the serializer may hold Done high into its idle cycle.
REQ-025 Latency: write at cycle N into an empty FIFO with an idle serializer gives o_TX_DV=1 at cycle N+2.
REQ-026 Back-to-back bytes: the next o_TX_DV follows i_TX_Done by 2 cycles (IDLE, then LAUNCH).
REQ-027 o_Irq sets when i_Irq_En=1, the FSM is in WAIT_DONE, i_TX_Done=1 and the FIFO is empty.
REQ-028 o_Irq clears on i_Irq_Clr or on any accepted write; set takes priority over clear in the same cycle.
REQ-029 o_Overflow clears only on i_Irq_Clr; a new overflow in the same cycle wins.
REQ-030 i_Irq_En low masks new o_Irq sets only; it does not clear an already set o_Irq.

Reset
REQ-031 During reset: FSM=IDLE, pointers=0, o_Count=0, o_Empty=1, o_Full=0, o_TX_DV=0, o_TX_Byte=0, o_Irq=0, o_Overflow=0.
REQ-032 Reset asserted mid-frame discards all queued bytes and drops o_TX_DV immediately (asynchronously).
REQ-033 After reset release, no launch occurs until a new write arrives.

Structure
REQ-034 Shared package uart_pkg holds: FSM state encoding (2 bits), the DEPTH default, and the byte width constant.
REQ-035 Storage lives in one sub-module, uart_byte_fifo (pointers, count, full/empty, overflow detect).
REQ-036 uart_tx_feeder holds the FSM and the interrupt logic; o_TX_DV, o_TX_Byte and o_Irq are registered outputs.

Verification
REQ-037 Write 0x55 into an empty FIFO with the serializer model idle -> o_TX_DV high at N+2 for 1 cycle with o_TX_Byte=0x55; o_Count returns to 0.
REQ-038 Burst-write 0x01..0x10 (16 bytes, DEPTH=16) while busy, then a 17th write 0xFF -> o_Full=1, o_Overflow=1, 0xFF never transmitted; bytes emerge in order 0x01..0x10.
REQ-039 i_Irq_En=1, send 1 byte, Done asserted for 2 cycles -> o_Irq=1 exactly once, single launch; then i_Irq_Clr -> o_Irq=0 next cycle.
REQ-040 FIFO holds 4 bytes, write issued on the pop edge -> o_Count stays 4; pointer wrap verified after 40 bytes total.
REQ-041 Assert i_Rst_L=0 while in WAIT_DONE with 3 bytes queued -> all outputs at reset values; release gives no o_TX_DV until the next write.
